// File: rtl/rom_access_arbiter_if.sv
// Request/response bundle between the CPU core, the ROM arbiter and the ROM.
// The slave side is the arbiter; the master side is the core plus ROM model.
interface rom_access_arbiter_if #(
  parameter int ADDR_W = 14
);
  logic              i_req_valid;
  logic              i_req_ready;
  logic [ADDR_W-1:0] i_req_addr;
  logic              i_resp_valid;
  logic [31:0]       i_resp_data;
  logic              i_resp_err;

  logic              d_req_valid;
  logic              d_req_ready;
  logic [ADDR_W-1:0] d_req_addr;
  logic              d_resp_valid;
  logic [31:0]       d_resp_data;
  logic              d_resp_err;

  logic [ADDR_W-1:0] rom_address;
  logic [31:0]       rom_data;

  modport slave (
    input  i_req_valid, i_req_addr, d_req_valid, d_req_addr, rom_data,
    output i_req_ready, i_resp_valid, i_resp_data, i_resp_err,
    output d_req_ready, d_resp_valid, d_resp_data, d_resp_err,
    output rom_address
  );

  modport master (
    output i_req_valid, i_req_addr, d_req_valid, d_req_addr, rom_data,
    input  i_req_ready, i_resp_valid, i_resp_data, i_resp_err,
    input  d_req_ready, d_resp_valid, d_resp_data, d_resp_err,
    input  rom_address
  );
endinterface

// File: rtl/rom_access_arbiter.sv
// Shares one synchronous-read ROM between instruction fetch (I) and data loads (D).
// One grant per cycle; the response comes back exactly one cycle later, tagged to its port.
module rom_access_arbiter #(
  parameter int ADDR_W    = 14,
  parameter bit DATA_PRIO = 1'b0
) (
  input logic                 clk,
  input logic                 reset,
  rom_access_arbiter_if.slave bus
);
  logic              grant_i;
  logic              grant_d;
  logic              accept_i;
  logic              accept_d;
  logic [ADDR_W-1:0] granted_addr;
  logic              i_inflight_reg;
  logic              d_inflight_reg;
  logic              err_reg;
  logic              last_grant_d_reg;

  // On a conflict, round-robin favours whichever port did not win last time.
  always_comb begin
    grant_i = 1'b0;
    grant_d = 1'b0;
    if (bus.i_req_valid && bus.d_req_valid) begin
      if (DATA_PRIO || !last_grant_d_reg) begin
        grant_d = 1'b1;
      end else begin
        grant_i = 1'b1;
      end
    end else begin
      grant_i = bus.i_req_valid;
      grant_d = bus.d_req_valid;
    end
  end

  assign accept_i = grant_i & ~reset;
  assign accept_d = grant_d & ~reset;

  always_comb begin
    granted_addr = '0;
    if (accept_i) begin
      granted_addr = bus.i_req_addr;
    end else if (accept_d) begin
      granted_addr = bus.d_req_addr;
    end
  end

  assign bus.i_req_ready = accept_i;
  assign bus.d_req_ready = accept_d;
  assign bus.rom_address = granted_addr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      i_inflight_reg   <= 1'b0;
      d_inflight_reg   <= 1'b0;
      err_reg          <= 1'b0;
      last_grant_d_reg <= 1'b1;
    end else begin
      i_inflight_reg <= accept_i;
      d_inflight_reg <= accept_d;
      if (accept_i || accept_d) begin
        err_reg          <= (granted_addr[1:0] != 2'b00);
        last_grant_d_reg <= accept_d;
      end
    end
  end

  // The ROM already read the word-truncated address; misaligned data is simply masked.
  assign bus.i_resp_valid = i_inflight_reg;
  assign bus.i_resp_err   = i_inflight_reg & err_reg;
  assign bus.i_resp_data  = (i_inflight_reg && !err_reg) ? bus.rom_data : 32'h0;

  assign bus.d_resp_valid = d_inflight_reg;
  assign bus.d_resp_err   = d_inflight_reg & err_reg;
  assign bus.d_resp_data  = (d_inflight_reg && !err_reg) ? bus.rom_data : 32'h0;
endmodule

// File: tb/tb_rom_access_arbiter.sv
// Scoreboard bench: two arbiters (round-robin and data-priority) see identical stimulus;
// expected responses are queued at issue time and popped by a negedge monitor.
module tb_rom_access_arbiter;
  localparam int ADDR_W = 14;
  localparam int WORDS  = 1 << (ADDR_W - 2);

  typedef struct {
    int          due;
    bit          port_d;
    logic [31:0] data;
    bit          err;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic              i_valid = 1'b0;
  logic [ADDR_W-1:0] i_addr  = '0;
  logic              d_valid = 1'b0;
  logic [ADDR_W-1:0] d_addr  = '0;

  rom_access_arbiter_if #(.ADDR_W(ADDR_W)) bus0 ();
  rom_access_arbiter_if #(.ADDR_W(ADDR_W)) bus1 ();

  rom_access_arbiter #(.ADDR_W(ADDR_W), .DATA_PRIO(1'b0)) dut0 (
    .clk(clk), .reset(reset), .bus(bus0.slave)
  );
  rom_access_arbiter #(.ADDR_W(ADDR_W), .DATA_PRIO(1'b1)) dut1 (
    .clk(clk), .reset(reset), .bus(bus1.slave)
  );

  assign bus0.i_req_valid = i_valid;
  assign bus0.i_req_addr  = i_addr;
  assign bus0.d_req_valid = d_valid;
  assign bus0.d_req_addr  = d_addr;
  assign bus1.i_req_valid = i_valid;
  assign bus1.i_req_addr  = i_addr;
  assign bus1.d_req_valid = d_valid;
  assign bus1.d_req_addr  = d_addr;

  // ROM model: registered address, combinational word read
  logic [31:0]       rom_mem [WORDS];
  logic [ADDR_W-1:0] rom_q0 = '0;
  logic [ADDR_W-1:0] rom_q1 = '0;
  always @(posedge clk) begin
    rom_q0 <= bus0.rom_address;
    rom_q1 <= bus1.rom_address;
  end
  assign bus0.rom_data = rom_mem[rom_q0[ADDR_W-1:2]];
  assign bus1.rom_data = rom_mem[rom_q1[ADDR_W-1:2]];

  // Per-instance views so checks can loop over both arbiters
  logic              i_rdy_w [2];
  logic              d_rdy_w [2];
  logic              i_rv_w  [2];
  logic              d_rv_w  [2];
  logic [31:0]       i_rd_w  [2];
  logic [31:0]       d_rd_w  [2];
  logic              i_re_w  [2];
  logic              d_re_w  [2];
  logic [ADDR_W-1:0] raddr_w [2];
  assign i_rdy_w[0] = bus0.i_req_ready;  assign i_rdy_w[1] = bus1.i_req_ready;
  assign d_rdy_w[0] = bus0.d_req_ready;  assign d_rdy_w[1] = bus1.d_req_ready;
  assign i_rv_w[0]  = bus0.i_resp_valid; assign i_rv_w[1]  = bus1.i_resp_valid;
  assign d_rv_w[0]  = bus0.d_resp_valid; assign d_rv_w[1]  = bus1.d_resp_valid;
  assign i_rd_w[0]  = bus0.i_resp_data;  assign i_rd_w[1]  = bus1.i_resp_data;
  assign d_rd_w[0]  = bus0.d_resp_data;  assign d_rd_w[1]  = bus1.d_resp_data;
  assign i_re_w[0]  = bus0.i_resp_err;   assign i_re_w[1]  = bus1.i_resp_err;
  assign d_re_w[0]  = bus0.d_resp_err;   assign d_re_w[1]  = bus1.d_resp_err;
  assign raddr_w[0] = bus0.rom_address;  assign raddr_w[1] = bus1.rom_address;

  exp_t q0[$];
  exp_t q1[$];
  bit   last_d [2];
  int   checks = 0;
  int   errors = 0;

  // Reference arbitration: 0 = nobody, 1 = I, 2 = D. Instance 1 is data-priority.
  function automatic int winner(int k, bit iv, bit dv);
    if (iv && dv) return (k == 1) ? 2 : (last_d[k] ? 1 : 2);
    if (iv) return 1;
    if (dv) return 2;
    return 0;
  endfunction

  task automatic model_reset();
    q0.delete();
    q1.delete();
    last_d[0] = 1'b1;
    last_d[1] = 1'b1;
  endtask

  task automatic drive(input bit iv, input logic [ADDR_W-1:0] ia,
                       input bit dv, input logic [ADDR_W-1:0] da);
    @(posedge clk);
    #1;
    i_valid = iv; i_addr = ia; d_valid = dv; d_addr = da;
    #1;
    for (int k = 0; k < 2; k++) begin
      int                w;
      logic [1:0]        exp_rdy;
      logic [ADDR_W-1:0] exp_addr;
      exp_t              e;
      w        = winner(k, iv, dv);
      exp_rdy  = {w == 2, w == 1};
      exp_addr = (w == 1) ? ia : ((w == 2) ? da : '0);
      checks++;
      if ({d_rdy_w[k], i_rdy_w[k]} !== exp_rdy) begin
        errors++;
        $display("FAIL ready dut%0d cyc=%0d got d/i=%b want %b", k, cyc,
                 {d_rdy_w[k], i_rdy_w[k]}, exp_rdy);
      end
      checks++;
      if (raddr_w[k] !== exp_addr) begin
        errors++;
        $display("FAIL rom_address dut%0d cyc=%0d got %h want %h", k, cyc, raddr_w[k], exp_addr);
      end
      if (w != 0) begin
        logic [ADDR_W-1:0] a;
        a        = (w == 2) ? da : ia;
        e.due    = cyc + 1;
        e.port_d = (w == 2);
        e.err    = (a[1:0] != 2'b00);
        e.data   = e.err ? 32'h0 : rom_mem[a[ADDR_W-1:2]];
        if (k == 0) q0.push_back(e); else q1.push_back(e);
        last_d[k] = (w == 2);
      end
    end
  endtask

  // Monitor: compares whatever the DUT presents against the scoreboard head.
  always @(negedge clk) begin
    if (!reset) begin
      for (int k = 0; k < 2; k++) begin
        exp_t        e;
        bit          have;
        logic [1:0]  got_v;
        logic [31:0] got_d;
        logic        got_e;
        have = 1'b0;
        if (k == 0 && q0.size() > 0 && q0[0].due == cyc) begin e = q0.pop_front(); have = 1'b1; end
        if (k == 1 && q1.size() > 0 && q1[0].due == cyc) begin e = q1.pop_front(); have = 1'b1; end
        got_v = {d_rv_w[k], i_rv_w[k]};
        checks++;
        if (!have) begin
          if (got_v !== 2'b00) begin
            errors++;
            $display("FAIL unexpected_resp dut%0d cyc=%0d got d/i valid=%b want 00", k, cyc, got_v);
          end
        end else if (got_v !== {e.port_d, !e.port_d}) begin
          errors++;
          $display("FAIL resp_valid dut%0d cyc=%0d got d/i valid=%b want %b", k, cyc, got_v,
                   {e.port_d, !e.port_d});
        end else begin
          got_d = e.port_d ? d_rd_w[k] : i_rd_w[k];
          got_e = e.port_d ? d_re_w[k] : i_re_w[k];
          $display("resp dut%0d cyc=%0d port=%s data=%h err=%b", k, cyc,
                   e.port_d ? "D" : "I", got_d, got_e);
          checks++;
          if ({got_e, got_d} !== {e.err, e.data}) begin
            errors++;
            $display("FAIL resp_data dut%0d cyc=%0d got err=%b data=%h want err=%b data=%h",
                     k, cyc, got_e, got_d, e.err, e.data);
          end
        end
      end
    end
  end

  initial begin
    for (int i = 0; i < WORDS; i++) rom_mem[i] = $urandom;
    rom_mem[1] = 32'hDEADBEEF;
    model_reset();

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({bus0.i_resp_valid, bus0.d_resp_valid, bus0.i_resp_err, bus0.d_resp_err,
         bus0.i_resp_data, bus0.d_resp_data} !== 68'h0) begin
      errors++;
      $display("FAIL reset_outputs got nonzero response outputs want all zero");
    end
    reset = 1'b0;

    // Single I fetch, then conflicts, then misaligned D load
    drive(1, 14'h0004, 0, '0);
    drive(0, '0, 0, '0);
    repeat (4) drive(1, 14'h0010, 1, 14'h0020);
    drive(0, '0, 0, '0);
    drive(0, '0, 1, 14'h0006);
    drive(0, '0, 0, '0);

    // Reset with a response in flight
    drive(1, 14'h0008, 0, '0);
    @(posedge clk);
    #2;
    checks++;
    if (bus0.i_resp_valid !== 1'b1) begin
      errors++;
      $display("FAIL inflight_before_reset got %b want 1", bus0.i_resp_valid);
    end
    reset = 1'b1;
    i_valid = 1'b1; d_valid = 1'b1;
    #1;
    model_reset();
    checks++;
    if ({bus0.i_resp_valid, bus1.i_resp_valid, bus0.i_req_ready, bus0.d_req_ready,
         bus1.i_req_ready, bus1.d_req_ready} !== 6'b0) begin
      errors++;
      $display("FAIL async_reset_drop got valid/ready nonzero want 0");
    end
    @(posedge clk);
    @(posedge clk);
    #3;
    i_valid = 1'b0; d_valid = 1'b0;
    reset = 1'b0;
    drive(0, '0, 0, '0);
    drive(1, 14'h0040, 1, 14'h0080);
    drive(0, '0, 0, '0);

    // Idle then a continuous fetch stream
    repeat (3) drive(0, '0, 0, '0);
    for (int i = 0; i < 4; i++) drive(1, ADDR_W'(4 * i), 0, '0);
    drive(0, '0, 0, '0);

    // Randomized traffic, including misaligned and top-of-ROM addresses
    for (int n = 0; n < 300; n++) begin
      logic [ADDR_W-1:0] ia;
      logic [ADDR_W-1:0] da;
      ia = ADDR_W'($urandom);
      da = ADDR_W'($urandom);
      if ($urandom_range(0, 7) != 0) ia[1:0] = 2'b00;
      if ($urandom_range(0, 7) != 0) da[1:0] = 2'b00;
      if ($urandom_range(0, 15) == 0) ia = 14'h3FFC;
      if ($urandom_range(0, 15) == 0) da = 14'h3FFC;
      drive(1'($urandom_range(0, 1)), ia, 1'($urandom_range(0, 1)), da);
    end
    drive(0, '0, 0, '0);
    drive(0, '0, 0, '0);
    @(posedge clk);
    #1;
    checks++;
    if (q0.size() + q1.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got %0d pending want 0", q0.size() + q1.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
